// File: rtl/argmax_classifier_if.sv
// Start/result bundle between the output layer and the argmax classifier.
// The classifier connects through the slave modport; the consumer drives through master.
interface argmax_classifier_if #(
   parameter int DATAWIDTH      = 16,
   parameter int OUTPUT_NEURONS = 10,
   parameter int INDEX_WIDTH    = 4
);
   logic                                start;
   logic [DATAWIDTH*OUTPUT_NEURONS-1:0] layer_data;
   logic                                busy;
   logic                                done;
   logic [INDEX_WIDTH-1:0]              class_index;
   logic [DATAWIDTH-1:0]                class_value;

   modport master (
      output start, layer_data,
      input  busy, done, class_index, class_value
   );

   modport slave (
      input  start, layer_data,
      output busy, done, class_index, class_value
   );
endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over the output layer: snapshot on start, one signed compare per clock,
// index/value of the largest element reported with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; start captures the layer bus and seeds best with element 0
// SCAN  | compares one snapshot element per cycle against the running best
// DONE  | one-cycle done pulse; class_index/class_value hold the final best
module argmax_classifier #(
   parameter int DATAWIDTH      = 16,
   parameter int OUTPUT_NEURONS = 10,
   parameter int INDEX_WIDTH    = 4
) (
   input logic                 clock,
   input logic                 reset,
   argmax_classifier_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(OUTPUT_NEURONS - 1);
   localparam logic [INDEX_WIDTH-1:0] FIRST_SCAN =
      (OUTPUT_NEURONS > 1) ? INDEX_WIDTH'(1) : INDEX_WIDTH'(0);

   state_t                       state, state_nxt;
   logic signed [DATAWIDTH-1:0]  snap [OUTPUT_NEURONS];
   logic signed [DATAWIDTH-1:0]  best_val, best_val_nxt, cur_val;
   logic [INDEX_WIDTH-1:0]       best_idx, best_idx_nxt;
   logic [INDEX_WIDTH-1:0]       scan_idx, scan_idx_nxt;
   logic [INDEX_WIDTH-1:0]       class_index_q, class_index_nxt;
   logic [DATAWIDTH-1:0]         class_value_q, class_value_nxt;
   logic                         busy_q, busy_nxt, done_q, done_nxt;
   logic                         capture;

   // Element select for the single comparator.
   always_comb begin
      cur_val = snap[0];
      for (int k = 1; k < OUTPUT_NEURONS; k++) begin
         if (scan_idx == INDEX_WIDTH'(k)) cur_val = snap[k];
      end
   end

   always_comb begin
      state_nxt       = state;
      capture         = 1'b0;
      best_val_nxt    = best_val;
      best_idx_nxt    = best_idx;
      scan_idx_nxt    = scan_idx;
      class_index_nxt = class_index_q;
      class_value_nxt = class_value_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               capture      = 1'b1;
               best_val_nxt = bus.layer_data[DATAWIDTH-1:0];
               best_idx_nxt = '0;
               scan_idx_nxt = FIRST_SCAN;
               if (OUTPUT_NEURONS > 1) begin
                  state_nxt = SCAN;
               end else begin
                  state_nxt       = DONE;
                  class_index_nxt = '0;
                  class_value_nxt = bus.layer_data[DATAWIDTH-1:0];
               end
            end
         end
         SCAN: begin
            // Strict greater-than keeps the lowest index on ties.
            if (cur_val > best_val) begin
               best_val_nxt = cur_val;
               best_idx_nxt = scan_idx;
            end
            if (scan_idx == LAST_IDX) begin
               state_nxt       = DONE;
               class_index_nxt = best_idx_nxt;
               class_value_nxt = best_val_nxt;
            end else begin
               scan_idx_nxt = scan_idx + INDEX_WIDTH'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         best_val      <= '0;
         best_idx      <= '0;
         scan_idx      <= '0;
         class_index_q <= '0;
         class_value_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int k = 0; k < OUTPUT_NEURONS; k++) snap[k] <= '0;
      end else begin
         state         <= state_nxt;
         best_val      <= best_val_nxt;
         best_idx      <= best_idx_nxt;
         scan_idx      <= scan_idx_nxt;
         class_index_q <= class_index_nxt;
         class_value_q <= class_value_nxt;
         busy_q        <= busy_nxt;
         done_q        <= done_nxt;
         if (capture) begin
            for (int k = 0; k < OUTPUT_NEURONS; k++)
               snap[k] <= bus.layer_data[DATAWIDTH*k +: DATAWIDTH];
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.class_index = class_index_q;
   assign bus.class_value = class_value_q;
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Downstream stage of the output layer of neurons.
- Captures the packed output-layer result bus on a start strobe and scans it sequentially, one element per clock, with a single signed comparator.
- Reports the index and value of the largest element with a one-cycle done pulse.
- Its result is the network's final classification, consumed by the top-level/test harness.

Parameters:
- DATAWIDTH, 16, width of one fixed-point element; same format as the neuron results.
- OUTPUT_NEURONS, 10, number of elements on the layer bus; must be >= 1.
- INDEX_WIDTH, 4, width of the class index; must satisfy 2**INDEX_WIDTH >= OUTPUT_NEURONS.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a classification; sampled only in IDLE.
- layer_data  input  DATAWIDTH*OUTPUT_NEURONS  packed neuron results; element k occupies bits [DATAWIDTH*k +: DATAWIDTH].
- busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.
- done  output  1  one-cycle pulse; class_index and class_value are valid in this cycle.
- class_index  output  INDEX_WIDTH  index of the maximum element.
- class_value  output  DATAWIDTH  value of the maximum element.

Behaviour:
- Reset state (async, immediate): state=IDLE; busy=0, done=0, class_index=0, class_value=0; internal scan index, best registers and snapshot cleared.
- States:
  - IDLE: start=1 captures all of layer_data into an internal snapshot. best_val<=element 0, best_idx<=0, scan_idx<=1. Go to SCAN if OUTPUT_NEURONS>1, else DONE.
  - SCAN: each cycle compare snapshot[scan_idx] against best_val as two's-complement signed. If strictly greater, best_val/best_idx <= snapshot[scan_idx]/scan_idx. scan_idx increments. After the element at OUTPUT_NEURONS-1 is processed, go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle; class_index/class_value hold final best; next state IDLE.
- Latency: start sampled at edge t -> done high in cycle t+OUTPUT_NEURONS. For N=1 the latency is 1.
- Back-to-back: start during SCAN or DONE is ignored, not queued. The earliest next accepted start is in the cycle after done.
- Snapshot: layer_data changes after the start edge do not affect the result.
- Ties: the lowest index wins, since only a strict > updates.
- Signed compare: negative values are valid; the 0x8000 minimum is handled correctly. ReLU'd inputs are simply a non-negative subset.
- Output hold: class_index/class_value update only on entering DONE and hold their values until the next DONE or reset. done is low in all states except DONE.
- Reset mid-operation: returns to IDLE at once with all outputs zeroed; the partial scan is discarded.
- The scan counter never exceeds OUTPUT_NEURONS-1; no wrap-around occurs.
- All outputs are registered; no combinational path from start or layer_data to any output.

Test Plan:
- Reset then idle: assert reset mid-cycle, hold 3 cycles, release -> busy=0, done=0, class_index=0, class_value=0 immediately and while idle with start=0.
- Basic argmax: N=10, elements {5,3,9,0x0100,2,0,7,1,4,6} with 0x0100 at index 3; start at t -> done only at t+10, class_index=3, class_value=0x0100, busy high t+1..t+10.
- Tie and signed: elements {0xFFFF,0x8000,0x0040,0x0040,0xFFF0,...rest 0xFFFF}; start -> class_index=2, class_value=0x0040. Then all-negative {0x8000 except index 7 = 0xFFFE} -> class_index=7.
- Snapshot and ignored start:
  - Start, then change layer_data to all 0x7FFF in the next cycle -> result reflects the original data.
  - start pulses during SCAN and DONE produce no second done.
  - start in the cycle after done is accepted, with its done 10 cycles later.
- Reset mid-scan: start, assert reset at t+4 -> done never pulses for that request and outputs are 0. New start after release -> correct result at +10 cycles.
- Max at edges: with N=10, max at index 0 (0x0500) -> class_index=0; max at index 9 -> class_index=9. With OUTPUT_NEURONS=1 instance, element 0x0123 -> done at t+1, class_index=0, class_value=0x0123.
